// File: rtl/cafe_scheduler.sv
// Round-robin scheduler that shares one coffee machine among N_REQ requesters,
// tracks each order through the machine's state codes and flags stuck/illegal machines.
module cafe_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       machine_state,
    input  logic             clr_err,
    output logic             machine_start,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             error,
    output logic [7:0]       served_count,
    output logic [2:0]       state_dbg
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    localparam logic [3:0] MS_IDLE    = 4'd1;
    localparam logic [3:0] MS_EXTRACT = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_LEAVE, S_WAIT_EXTRACT, S_WAIT_RETURN, S_DONE, S_ERROR
    } state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  ptr, idx, idx_inc, winner;
    logic [7:0]     wd_cnt;
    logic           found, legal, wd_hit, in_wait;

    function automatic logic [IW-1:0] rr_pos(input logic [IW-1:0] base, input int k);
        int p;
        p = (int'(base) + k) % N_REQ;
        return IW'(p);
    endfunction

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[rr_pos(ptr, k)]) begin
                found  = 1'b1;
                winner = rr_pos(ptr, k);
            end
        end
    end

    assign idx_inc = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    assign legal   = (machine_state != 4'd0) && (machine_state <= MS_EXTRACT);
    assign in_wait = (state == S_WAIT_LEAVE) || (state == S_WAIT_EXTRACT) ||
                     (state == S_WAIT_RETURN);
    // wd_cnt+1 is the number of cycles elapsed since the start strobe, so the
    // error state is entered exactly TIMEOUT cycles after S_START.
    assign wd_hit  = (wd_cnt + 8'd1) >= 8'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:         if (found && machine_state == MS_IDLE) state_nxt = S_START;
            S_START:        state_nxt = S_WAIT_LEAVE;
            S_WAIT_LEAVE: begin
                if (!legal || wd_hit)                state_nxt = S_ERROR;
                else if (machine_state != MS_IDLE)   state_nxt = S_WAIT_EXTRACT;
            end
            S_WAIT_EXTRACT: begin
                if (!legal || wd_hit)                state_nxt = S_ERROR;
                else if (machine_state == MS_EXTRACT) state_nxt = S_WAIT_RETURN;
            end
            S_WAIT_RETURN: begin
                if (!legal || wd_hit)                state_nxt = S_ERROR;
                else if (machine_state == MS_IDLE)   state_nxt = S_DONE;
            end
            S_DONE:         state_nxt = S_IDLE;
            S_ERROR:        if (clr_err) state_nxt = S_IDLE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            idx          <= '0;
            wd_cnt       <= '0;
            served_count <= '0;
        end else begin
            if (state == S_IDLE && state_nxt == S_START) idx <= winner;
            if (state == S_START)  wd_cnt <= '0;
            else if (in_wait)      wd_cnt <= wd_cnt + 8'd1;
            if (state == S_DONE) begin
                served_count <= served_count + 8'd1;
                ptr          <= idx_inc;
            end
            if (state == S_ERROR && clr_err) ptr <= idx_inc;
        end
    end

    // machine_start and done are single-cycle strobes with no back-pressure:
    // the machine must accept a start whenever it reports IDLE.
    always_comb begin
        machine_start = (state == S_START);
        busy          = (state != S_IDLE);
        error         = (state == S_ERROR);
        grant         = '0;
        done          = '0;
        if (state != S_IDLE && state != S_ERROR) grant = ONE << idx;
        if (state == S_DONE)                     done  = ONE << idx;
        state_dbg     = state;
    end
endmodule

// File: doc/cafe_scheduler.md
# cafe_scheduler

Round-robin order scheduler sharing one coffee-machine FSM among `N_REQ` requesters. It sits between the order inputs and the machine, observes the machine's 4-bit state code, and issues a one-cycle `machine_start`. It tracks each order to completion, then returns a per-requester `done` pulse. A watchdog flags a stuck or illegal machine as a sticky error.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 32: max cycles from `machine_start` to completion before error (≤255).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: level requests; bit i held high while requester i wants a coffee.
- `machine_state` in 4: state code from the machine: 1=IDLE, 2..8=intermediate, 9=REALIZAR_EXTRACAO; 0 and 10..15 are illegal.
- `clr_err` in 1: leaves ERROR when high.
- `machine_start` out 1: start strobe to the machine.
- `grant` out N_REQ: one-hot, identifies the requester being served.
- `done` out N_REQ: one-cycle completion pulse for the served requester.
- `busy` out 1: high in any state except S_IDLE.
- `error` out 1: high while in S_ERROR.
- `served_count` out 8: count of completed orders, wraps 255→0.

## Operation
- FSM states: S_IDLE, S_START, S_WAIT_LEAVE, S_WAIT_EXTRACT, S_WAIT_RETURN, S_DONE, S_ERROR.
- **S_IDLE**
  - When `req`≠0 and `machine_state`==1, pick the winner: the first set bit at or above `ptr`, searching upward with wrap.
  - Register the winner index and go to S_START.
  - Otherwise stay in S_IDLE. If `machine_state`≠1, never start.
- **S_START**
  - `machine_start`=1 for exactly this cycle.
  - Clear the watchdog counter and go to S_WAIT_LEAVE.
- **S_WAIT_LEAVE**: go to S_WAIT_EXTRACT once `machine_state`≠1.
- **S_WAIT_EXTRACT**: go to S_WAIT_RETURN once `machine_state`==9.
- **S_WAIT_RETURN**: go to S_DONE once `machine_state`==1.
- **S_DONE**
  - `done[idx]`=1 for this cycle only.
  - `served_count` increments.
  - `ptr` ← (idx+1) mod N_REQ.
  - Go to S_IDLE.
- **S_ERROR**
  - `error`=1, `grant`=0, no `done` pulse.
  - Leave to S_IDLE when `clr_err`=1, with `ptr` ← (idx+1) mod N_REQ.
- **Watchdog**
  - The 8-bit counter increments every cycle in the three S_WAIT_* states.
  - Reaching `TIMEOUT` → S_ERROR.
  - An illegal `machine_state` in any S_WAIT_* state → S_ERROR immediately, on the next edge.
  - If both conditions occur in the same cycle, the result is S_ERROR.
- **Grant and requests**
  - `grant` is one-hot of idx in states S_START..S_DONE inclusive, 0 elsewhere.
  - Dropping `req[idx]` mid-service does not abort the order; `done[idx]` still pulses.
  - New or changing requests are ignored until S_IDLE.
- **Reset** (any time, including mid-order)
  - FSM=S_IDLE, `ptr`=0, idx=0, counter=0, `served_count`=0.
  - All outputs 0: `machine_start`, `grant`, `done`, `busy`, `error`.

## Timing
- All outputs are decoded from registered state only (Moore); there are no combinational paths from inputs to outputs.
- Request sampled in S_IDLE at edge t0:
  - S_START, with `grant` and `machine_start`, during cycle t0+1.
  - The machine leaves IDLE at t0+2.
- Completion latency versus the connected machine:
  - First order after the machine's reset includes the reservoir fill, so `done` pulses in cycle t0+12.
  - Later orders: `done` in cycle t0+10.
- Back-to-back: the earliest next S_START is 2 cycles after S_DONE, one cycle spent in S_IDLE.
- With `TIMEOUT`=32 and a machine frozen at 1: S_ERROR is entered 32 cycles after S_START.

## Test plan
- Single order, real machine attached, fresh reset:
  - Stimulus: `req`=4'b0001 at t0.
  - Required: `grant`=0001 during t0+1..t0+12; `machine_start` only at t0+1; `done`=0001 only at t0+12; `served_count`=1.
  - A second `req`=0001 order → `done` 10 cycles after its sample.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001.
  - Second case: `req`=4'b0101 from `ptr`=0 → 0001 then 0100.
- Request dropped mid-order:
  - Stimulus: `req`=0010, deasserted at t0+4.
  - Required: the order completes and `done`=0010 still pulses; no new start follows.
- Stuck machine:
  - Stimulus: model holds `machine_state`=1 after start, `TIMEOUT`=32.
  - Required: `error`=1 after 32 wait cycles; `grant`=0; no `done`.
  - `clr_err`=1 → S_IDLE; the next grant goes to the next requester.
- Illegal code: `machine_state`=0 in S_WAIT_EXTRACT → `error`=1 on the next cycle.
- Reset mid-order:
  - Stimulus: `rst_n`=0 during S_WAIT_EXTRACT.
  - Required: all outputs 0 immediately; `served_count`=0; `ptr`=0.
  - Counter wrap: 256 completed orders → `served_count`=0.
